// File: rtl/hamming_decoder.sv
// hamming_decoder
// Serial SECDED decoder for 16-bit extended Hamming frames.
// A frame arrives one bit per accepted cycle, position 0 first. Position 0
// is overall even parity, positions 1/2/4/8 are Hamming parity, and the
// other 11 positions carry data. The syndrome and overall parity are built
// up as bits arrive. One CHECK cycle then classifies the frame and repairs
// a single-bit error. The 11 data bits are streamed out under valid/ready.
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst           synchronous active-high reset
//   in_valid      in_bit carries the next frame bit
//   in_bit        serial frame bit, position 0 first
//   in_ready      decoder can accept a frame bit this cycle
//   out_valid     out_bit holds a decoded data bit
//   out_bit       decoded data bit
//   out_last      marks the 11th (final) data bit of the frame
//   out_ready     downstream accepts out_bit this cycle
//   status_valid  one-cycle strobe on the first output cycle of a frame
//   err_single    single-bit error detected and corrected
//   err_double    uncorrectable double-bit error detected
//   err_pos       raw syndrome (erroneous position when err_single)

module hamming_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  input  logic       out_ready,
  output logic       status_valid,
  output logic       err_single,
  output logic       err_double,
  output logic [3:0] err_pos
);

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] frame;
  logic [3:0]  cnt;
  logic [3:0]  syn;
  logic        par;
  logic [3:0]  k;
  logic [3:0]  data_pos;

  // Map the output beat index to its frame position. These are all
  // positions that are not a power of two and not zero.
  always_comb begin
    data_pos = 4'd3;
    case (k)
      4'd0:    data_pos = 4'd3;
      4'd1:    data_pos = 4'd5;
      4'd2:    data_pos = 4'd6;
      4'd3:    data_pos = 4'd7;
      4'd4:    data_pos = 4'd9;
      4'd5:    data_pos = 4'd10;
      4'd6:    data_pos = 4'd11;
      4'd7:    data_pos = 4'd12;
      4'd8:    data_pos = 4'd13;
      4'd9:    data_pos = 4'd14;
      4'd10:   data_pos = 4'd15;
      default: data_pos = 4'd3;
    endcase
  end

  assign in_ready  = (state == RECV);
  assign out_valid = (state == SEND);
  // Gate with out_valid so the unreset frame register never leaks out.
  assign out_bit   = out_valid & frame[data_pos];
  assign out_last  = out_valid && (k == 4'd10);

  // The frame register is left out of the reset branch. Its contents are
  // only observed after a full 16-bit frame has overwritten every position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RECV;
      cnt          <= 4'd0;
      syn          <= 4'd0;
      par          <= 1'b0;
      k            <= 4'd0;
      status_valid <= 1'b0;
      err_single   <= 1'b0;
      err_double   <= 1'b0;
      err_pos      <= 4'd0;
    end else begin
      status_valid <= 1'b0;
      case (state)
        RECV: begin
          if (in_valid) begin
            frame[cnt] <= in_bit;
            // XOR of the indices of all set bits gives the syndrome directly.
            syn        <= syn ^ (in_bit ? cnt : 4'd0);
            par        <= par ^ in_bit;
            cnt        <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          // Odd overall parity means exactly one bit flipped, located at
          // syn. When syn is 0, the hit bit is position 0 and the data is
          // unaffected. Even parity with a nonzero syndrome is a double error.
          if (par) begin
            frame[syn] <= ~frame[syn];
          end
          err_single   <= par;
          err_double   <= ~par && (syn != 4'd0);
          err_pos      <= syn;
          syn          <= 4'd0;
          par          <= 1'b0;
          status_valid <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (k == 4'd10) begin
              k     <= 4'd0;
              state <= RECV;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Serial SECDED decoder for the 16-bit extended Hamming frames produced by the team's serial encoder. It accepts one frame bit per accepted cycle, in position order 0 to 15:
- position 0 is overall even parity;
- positions 1, 2, 4, 8 are Hamming parity;
- the remaining 11 positions are data.

It computes the syndrome incrementally, classifies the frame and corrects single-bit errors. It then streams the 11 data bits out serially under a valid/ready handshake, with a one-cycle status strobe. It sits on the receive side of the serial link, downstream of the bit sampler.

## Interface
Parameters: none (frame geometry fixed at 16/11).

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit carries the next frame bit
- in_bit  in  1  serial frame bit, position 0 first
- in_ready  out  1  decoder can accept a frame bit this cycle
- out_valid  out  1  out_bit holds a decoded data bit
- out_bit  out  1  decoded data bit
- out_last  out  1  qualifies the 11th (final) data bit of the frame
- out_ready  in  1  downstream accepts out_bit this cycle
- status_valid  out  1  one-cycle strobe; status outputs updated
- err_single  out  1  single-bit error detected and corrected
- err_double  out  1  uncorrectable double-bit error detected
- err_pos  out  4  raw syndrome (erroneous position when err_single)

## Operation
- State RECV: in_ready=1.
  - On in_valid&in_ready: frame[cnt]<=in_bit; syn<=syn^(in_bit?cnt:0); par<=par^in_bit; cnt<=cnt+1.
  - When the accept has cnt==15, go to CHECK; cnt wraps to 0.
- State CHECK (one cycle): in_ready=0. Classification:
  - par==0, syn==0: clean.
  - par==1: single error at position syn. Flip frame[syn]; syn==0 means the overall parity bit was hit and data is unaffected.
  - par==0, syn!=0: double error; frame left uncorrected.
  - Register err_single, err_double, err_pos<=syn. Clear syn and par. Go to SEND.
- State SEND: in_ready=0, out_valid=1.
  - out_bit=frame[pos[k]], where pos = 3,5,6,7,9,10,11,12,13,14,15 for k=0..10.
  - k advances only on out_valid&out_ready. out_bit is stable while out_ready=0.
  - out_last=1 when k==10. The handshake on k==10 returns to RECV with k=0.
- status_valid pulses high for exactly the first SEND cycle.
- err_single, err_double and err_pos hold until the next CHECK.
- err_single and err_double are never both 1.
- in_bit is ignored when in_valid=0 or in_ready=0.

## Timing
- Reset values (clk edge with rst=1): state RECV, cnt=0, k=0, syn=0, par=0.
  - Outputs after reset: in_ready=1; out_valid, out_bit, out_last, status_valid, err_single, err_double=0; err_pos=0.
  - The frame register need not be reset.
- Reset mid-frame or mid-SEND aborts the frame. The next accepted bit is position 0.
- Latency: last frame bit accepted at edge N.
  - CHECK occupies cycle N+1.
  - out_valid and status_valid are first high in cycle N+2.
  - The minimum frame-to-frame period is 16+1+11 = 28 cycles.
- in_ready falls in the cycle after the 16th accept. It rises in the cycle after the out_last handshake.
- in_valid gaps during RECV stall cnt without affecting syn or par.

## Test plan
- Clean frame 16'hFFFF (bit i = position i, data all ones):
  - 11 out_bit=1 with out_last on the 11th;
  - status_valid one cycle; err_single=0, err_double=0, err_pos=0;
  - out_valid first at N+2.
- 16'hFFBF (position 6 flipped) -> err_single=1, err_pos=6, all 11 data bits 1.
- 16'hFFFE (position 0 flipped) -> err_single=1, err_pos=0, data all ones.
- 16'hFFD7 (positions 3 and 5 flipped) -> err_double=1, err_single=0, err_pos=6; data uncorrected: 0,0,1,1,1,1,1,1,1,1,1.
- Backpressure: frame 16'h0000 with out_ready low on alternate cycles -> out_bit stable and k held while stalled; 11 beats; in_ready=0 until the cycle after the final handshake.
- Reset after 7 accepted bits, then 16'hFFFF with random in_valid gaps -> decoded as clean, no flags from the aborted frame.
